program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 161 ++++++++++++++++
 tb/tb_program_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: receives a framed byte stream (sync, length, words, XOR checksum)
// and writes the words into instruction memory while holding the CPU in reset.
module program_loader #(
    parameter int         MAX_WORDS = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        IDLE, SYNC, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_reg, state_next;
    logic [15:0] n_reg;
    logic [7:0]  csum_reg;
    logic [1:0]  byte_idx_reg;
    logic [23:0] shift_reg;
    logic        byte_ready_reg;
    logic        imem_we_reg;
    logic [31:0] imem_addr_reg;
    logic [31:0] imem_wdata_reg;
    logic        cpu_hold_reg;
    logic        load_done_reg;
    logic        load_error_reg;
    logic [15:0] word_count_reg;

    logic        fire;
    logic        idle_like;
    logic [15:0] n_full;
    logic        last_word;
    logic        word_end;

    assign fire      = byte_valid & byte_ready_reg;
    assign idle_like = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR);
    assign n_full    = {byte_data, n_reg[7:0]};
    assign last_word = ({1'b0, word_count_reg} + 17'd1) == {1'b0, n_reg};
    assign word_end  = (state_reg == DATA) && fire && (byte_idx_reg == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (start) state_next = SYNC;
            end
            SYNC: begin
                if (fire && byte_data == SYNC_BYTE) state_next = CNT_LO;
            end
            CNT_LO: begin
                if (fire) state_next = CNT_HI;
            end
            CNT_HI: begin
                if (fire) begin
                    if (n_full == 16'd0)                  state_next = CHECK;
                    else if ({1'b0, n_full} > MAX_LEN)    state_next = ERROR;
                    else                                  state_next = DATA;
                end
            end
            DATA: begin
                if (word_end && last_word) state_next = CHECK;
            end
            CHECK: begin
                if (fire) state_next = (byte_data == csum_reg) ? DONE : ERROR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath; byte_ready is registered from the next state so it tracks state_reg exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_reg          <= '0;
            csum_reg       <= '0;
            byte_idx_reg   <= '0;
            shift_reg      <= '0;
            byte_ready_reg <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            cpu_hold_reg   <= 1'b0;
            load_done_reg  <= 1'b0;
            load_error_reg <= 1'b0;
            word_count_reg <= '0;
        end else begin
            imem_we_reg    <= 1'b0;
            byte_ready_reg <= (state_next == SYNC) || (state_next == CNT_LO) ||
                              (state_next == CNT_HI) || (state_next == DATA) ||
                              (state_next == CHECK);
            if (idle_like && start) begin
                load_done_reg  <= 1'b0;
                load_error_reg <= 1'b0;
                word_count_reg <= '0;
                csum_reg       <= '0;
                byte_idx_reg   <= '0;
                cpu_hold_reg   <= 1'b1;
            end
            if (fire) begin
                case (state_reg)
                    CNT_LO: n_reg[7:0] <= byte_data;
                    CNT_HI: begin
                        n_reg[15:8] <= byte_data;
                        if ({1'b0, n_full} > MAX_LEN) load_error_reg <= 1'b1;
                    end
                    DATA: begin
                        csum_reg     <= csum_reg ^ byte_data;
                        shift_reg    <= {byte_data, shift_reg[23:8]};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                    end
                    CHECK: begin
                        if (byte_data == csum_reg) begin
                            load_done_reg <= 1'b1;
                            cpu_hold_reg  <= 1'b0;
                        end else begin
                            load_error_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // Fourth byte completes the word: the write pulse appears on the following cycle.
            if (word_end) begin
                imem_we_reg    <= 1'b1;
                imem_wdata_reg <= {byte_data, shift_reg};
                imem_addr_reg  <= {16'd0, word_count_reg};
                word_count_reg <= word_count_reg + 16'd1;
            end
        end
    end

    assign byte_ready = byte_ready_reg;
    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign cpu_hold   = cpu_hold_reg;
    assign load_done  = load_done_reg;
    assign load_error = load_error_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a frame-level reference model predicts
// memory writes and final status; a negedge monitor consumes and checks them.
module tb_program_loader;

    localparam int MAXW = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    always #5 clock = ~clock;

    program_loader #(.MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    // Counters and monitor bookkeeping are written only by the monitor process.
    int n_cmp = 0;
    int n_bad = 0;
    int rd_idx = 0;
    int status_ack = 0;
    int timeout_ack = 0;

    // Written only by the stimulus process.
    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];
    int status_seq = 0;
    int status_kind = 0;
    int timeout_seq = 0;
    bit exp_complete, exp_done, exp_err;
    int exp_cnt;
    bit tx_abort;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endfunction

    always @(negedge clock) begin
        if (imem_we) begin
            if (rd_idx >= exp_q.size()) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%h required no write", imem_addr, imem_wdata);
            end else begin
                $display("write addr=%0d data=%h", imem_addr, imem_wdata);
                check("write", {imem_addr, imem_wdata}, exp_q[rd_idx]);
                rd_idx++;
            end
        end
        if (load_done && load_error) begin
            n_cmp++;
            n_bad++;
            $display("FAIL flags_exclusive: got done=1 error=1 required not both");
        end
        if (timeout_seq != timeout_ack) begin
            timeout_ack = timeout_seq;
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: got byte_ready=0 for 40 cycles required acceptance");
        end
        if (status_seq != status_ack) begin
            status_ack = status_seq;
            check("pending_writes", 64'(exp_q.size() - rd_idx), 64'd0);
            if (status_kind == 1) begin
                $display("frame status done=%0b err=%0b hold=%0b count=%0d", load_done, load_error, cpu_hold, word_count);
                check("load_done", 64'(load_done), 64'(exp_done));
                check("load_error", 64'(load_error), 64'(exp_err));
                check("cpu_hold", 64'(cpu_hold), 64'(!exp_done));
                check("word_count", 64'(word_count), 64'(exp_cnt));
                check("byte_ready_idle", 64'(byte_ready), 64'd0);
            end else begin
                $display("reset status check");
                check("rst_outputs",
                      {byte_ready, imem_we, cpu_hold, load_done, load_error, word_count},
                      64'd0);
                check("rst_addr", 64'(imem_addr), 64'd0);
                check("rst_wdata", 64'(imem_wdata), 64'd0);
            end
        end
    end

    // Frame-level reference: walk the byte list as the frame format describes it.
    function automatic void model_frame();
        int i = 0;
        int n;
        logic [7:0] x = 8'h00;
        exp_complete = 0;
        exp_done = 0;
        exp_err = 0;
        exp_cnt = 0;
        while (i < tx_q.size() && tx_q[i] != 8'hA5) i++;
        if (i >= tx_q.size()) return;
        i++;
        if (i + 2 > tx_q.size()) return;
        n = int'(tx_q[i]) + 256 * int'(tx_q[i+1]);
        i += 2;
        if (n > MAXW) begin
            exp_complete = 1;
            exp_err = 1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (i + 4 > tx_q.size()) return;
            exp_q.push_back({32'(w), tx_q[i+3], tx_q[i+2], tx_q[i+1], tx_q[i]});
            x = x ^ tx_q[i] ^ tx_q[i+1] ^ tx_q[i+2] ^ tx_q[i+3];
            exp_cnt++;
            i += 4;
        end
        if (i >= tx_q.size()) return;
        exp_complete = 1;
        if (tx_q[i] == x) exp_done = 1;
        else exp_err = 1;
    endfunction

    task automatic build_frame(input int n, input int junk, input bit bad_csum);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        tx_q.delete();
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            tx_q.push_back(b);
        end
        tx_q.push_back(8'hA5);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        if (n > MAXW) return;
        for (int j = 0; j < 4 * n; j++) begin
            b = 8'($urandom_range(0, 255));
            x = x ^ b;
            tx_q.push_back(b);
        end
        if (bad_csum) x = x ^ 8'($urandom_range(1, 255));
        tx_q.push_back(x);
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit pulse_start);
        int t = 0;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            start = (pulse_start && g == 0);
            @(negedge clock);
            start = 1'b0;
        end
        byte_valid = 1'b1;
        byte_data = b;
        while (!byte_ready && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (!byte_ready) begin
            timeout_seq++;
            tx_abort = 1;
            byte_valid = 1'b0;
            @(negedge clock);
            return;
        end
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic request_status(input int kind);
        @(posedge clock);
        status_kind = kind;
        status_seq++;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic run_frame(input int gap_fixed, input int gap_rand, input int pulse_at);
        int g;
        tx_abort = 0;
        model_frame();
        do_start();
        for (int i = 0; i < tx_q.size(); i++) begin
            g = gap_fixed + ((gap_rand > 0) ? $urandom_range(0, gap_rand) : 0);
            send(tx_q[i], g, i == pulse_at);
            if (tx_abort) break;
        end
        repeat (3) @(negedge clock);
        if (exp_complete) request_status(1);
    endtask

    task automatic ref_frame(input logic [7:0] csum);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        tx_q[11] = csum;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clock);
        request_status(2);
        reset = 1'b0;

        ref_frame(8'h88);
        run_frame(0, 0, -1);
        ref_frame(8'h00);
        run_frame(0, 0, -1);
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(0, 0, -1);
        tx_q = '{8'hA5, 8'h01, 8'h01};
        run_frame(0, 0, -1);
        ref_frame(8'h88);
        run_frame(3, 0, 5);

        // Abandon a frame after its sixth data byte, then reload from scratch.
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        tx_abort = 0;
        model_frame();
        do_start();
        foreach (tx_q[i]) send(tx_q[i], 0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        status_kind = 2;
        status_seq++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        ref_frame(8'h88);
        run_frame(0, 0, -1);

        build_frame(MAXW, 0, 1'b0);
        run_frame(0, 0, -1);
        build_frame(MAXW + 1, 0, 1'b0);
        run_frame(0, 0, -1);

        for (int k = 0; k < 25; k++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? MAXW + 1 + $urandom_range(0, 60000)
                                            : $urandom_range(0, 6);
            build_frame(n, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
            run_frame(0, $urandom_range(0, 2), -1);
        end

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
